clk_en_monitor: RTL and testbench

Receive-side checker for the sample/symbol clock-enable strobes produced by the enable generator. It runs in the clk domain where the strobes are consumed, checks sample spacing and samples-per-symbol framing, and raises single-cycle error pulses. A SEARCH/ACQUIRE/LOCKED state machine reports whether the strobe pattern is stable enough for the downstream datapath.

---
 rtl/clk_en_monitor_if.sv | 21 ++
 rtl/clk_en_monitor.sv | 110 +++++++++++
 tb/tb_clk_en_monitor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/clk_en_monitor_if.sv
// clk_en_monitor_if: strobe inputs and status outputs of the clock-enable monitor.
interface clk_en_monitor_if #(
    parameter int SAM_PER_SYM = 4
);
    localparam int IW = SAM_PER_SYM > 1 ? $clog2(SAM_PER_SYM) : 1;
    logic          sam_clk_en;
    logic          sym_clk_en;
    logic          locked;
    logic          sam_err;
    logic          sym_err;
    logic [IW-1:0] sam_idx;
    logic [7:0]    err_cnt;
    modport master (
        output sam_clk_en, sym_clk_en,
        input  locked, sam_err, sym_err, sam_idx, err_cnt
    );
    modport slave (
        input  sam_clk_en, sym_clk_en,
        output locked, sam_err, sym_err, sam_idx, err_cnt
    );
endinterface

// File: rtl/clk_en_monitor.sv
// clk_en_monitor: checks sample spacing and symbol framing of clock-enable strobes and tracks lock.
module clk_en_monitor #(
    parameter int CYC_PER_SAM = 4,
    parameter int SAM_PER_SYM = 4,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2
) (
    input logic             clk,
    input logic             reset,
    clk_en_monitor_if.slave m
);
    localparam int IW = SAM_PER_SYM > 1 ? $clog2(SAM_PER_SYM) : 1;
    localparam int GW = $clog2(CYC_PER_SAM + 2);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    localparam logic [GW-1:0] GAP_NOM   = GW'(CYC_PER_SAM);
    localparam logic [GW-1:0] GAP_MAX   = GW'(CYC_PER_SAM + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(SAM_PER_SYM - 1);
    localparam logic [LW-1:0] GOOD_LOCK = LW'(LOCK_CNT);
    localparam logic [UW-1:0] BAD_DROP  = UW'(UNLOCK_CNT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [IW-1:0] sam_idx_q, sam_idx_d;
    logic [LW-1:0] good_q, good_d;
    logic [UW-1:0] bad_q, bad_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic          seen_q, seen_d, miss_q, miss_d, dirty_q, dirty_d;
    logic          sam_err_q, sam_err_d, sym_err_q, sym_err_d;
    logic          sam, sym, early, missing, sym_fault, active, fault, dirty;

    assign sam = m.sam_clk_en;
    assign sym = m.sym_clk_en;

    always_comb begin
        active    = state_q != SEARCH;
        early     = seen_q && sam && gap_q < GAP_NOM;
        // miss_q keeps a saturated gap from being flagged again until the next strobe
        missing   = seen_q && !sam && gap_q == GAP_MAX && !miss_q;
        sym_fault = sym ? (!sam || sam_idx_q != IDX_LAST) : (sam && sam_idx_q == IDX_LAST);
        sam_err_d = active && (early || missing);
        sym_err_d = active && sym_fault;
        fault     = sam_err_d || sym_err_d;
        dirty     = dirty_q || fault;
        dirty_d   = active && !sym && dirty;
        gap_d     = sam ? GW'(1) : (gap_q == GAP_MAX ? gap_q : gap_q + 1'b1);
        miss_d    = !sam && (miss_q || missing);
        seen_d    = seen_q || sam;
        sam_idx_d = !sam ? sam_idx_q : ((sym || sam_idx_q == IDX_LAST) ? '0 : sam_idx_q + 1'b1);
        err_cnt_d = (fault && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        case (state_q)
            SEARCH: if (sym) begin
                state_d = ACQUIRE;
                good_d  = '0;
            end
            ACQUIRE: if (fault || (sym && dirty)) good_d = '0;
            else if (sym) begin
                good_d = good_q + 1'b1;
                if (good_d == GOOD_LOCK) begin
                    state_d = LOCKED;
                    bad_d   = '0;
                end
            end
            LOCKED: if (sym) begin
                bad_d = dirty ? bad_q + 1'b1 : '0;
                if (bad_d == BAD_DROP) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            gap_q     <= '0;
            sam_idx_q <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            err_cnt_q <= '0;
            seen_q    <= 1'b0;
            miss_q    <= 1'b0;
            dirty_q   <= 1'b0;
            sam_err_q <= 1'b0;
            sym_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            sam_idx_q <= sam_idx_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
            seen_q    <= seen_d;
            miss_q    <= miss_d;
            dirty_q   <= dirty_d;
            sam_err_q <= sam_err_d;
            sym_err_q <= sym_err_d;
        end
    end

    assign m.locked  = state_q == LOCKED;
    assign m.sam_err = sam_err_q;
    assign m.sym_err = sym_err_q;
    assign m.sam_idx = sam_idx_q;
    assign m.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_clk_en_monitor.sv
// tb_clk_en_monitor: directed vectors and symbol-level sequences with hand-computed expectations.
module tb_clk_en_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    clk_en_monitor_if #(.SAM_PER_SYM(4)) bus ();
    clk_en_monitor #(
        .CYC_PER_SAM(4), .SAM_PER_SYM(4), .LOCK_CNT(4), .UNLOCK_CNT(2)
    ) dut (
        .clk(clk), .reset(reset), .m(bus.slave)
    );

    typedef struct {
        logic sam;
        logic sym;
        logic se;
        logic ye;
        int   idx;
        logic lk;
        int   err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int sam_n, sym_n, sam_k, sym_k, lock_k, unlock_k;
    vec_t tbl [13];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic sa, input logic sy);
        bus.sam_clk_en = sa;
        bus.sym_clk_en = sy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int lk, input int se, input int ye, input int idx, input int err);
        chk({tag, " locked"}, bus.locked, lk);
        chk({tag, " sam_err"}, bus.sam_err, se);
        chk({tag, " sym_err"}, bus.sym_err, ye);
        chk({tag, " sam_idx"}, bus.sam_idx, idx);
        chk({tag, " err_cnt"}, bus.err_cnt, err);
    endtask

    // One symbol of strobes: sample s at k=4s-shift, optional dropped sample, missing sym, stray sym.
    task automatic run_sym(input int drop, input bit no_sym, input int shift, input int stray, input bit chk_idx);
        int   len;
        int   s;
        logic sa;
        len = 16 - shift;
        sam_n = 0; sym_n = 0; sam_k = -1; sym_k = -1; lock_k = -1; unlock_k = -1;
        for (int k = 0; k < len; k++) begin
            s  = (k + shift) / 4;
            sa = (k == 0) || ((k + shift) % 4 == 0 && s != drop);
            cyc(sa, (k == 0 && !no_sym) || k == stray);
            if (bus.sam_err) begin sam_n++; if (sam_k < 0) sam_k = k; end
            if (bus.sym_err) begin sym_n++; if (sym_k < 0) sym_k = k; end
            if (bus.locked && lock_k < 0) lock_k = k;
            if (!bus.locked && unlock_k < 0) unlock_k = k;
            if (chk_idx && sa) chk($sformatf("sam_idx k%0d", k), bus.sam_idx, s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        cyc(0, 0);
        cyc(0, 0);
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // SEARCH suppresses faults; stray sym enters ACQUIRE; then early and stray faults are reported
        tbl = '{
            '{1, 0, 0, 0, 1, 0, 0}, '{1, 0, 0, 0, 2, 0, 0}, '{0, 1, 0, 0, 2, 0, 0},
            '{0, 0, 0, 0, 2, 0, 0}, '{0, 0, 0, 0, 2, 0, 0}, '{1, 0, 0, 0, 3, 0, 0},
            '{0, 0, 0, 0, 3, 0, 0}, '{0, 0, 0, 0, 3, 0, 0}, '{0, 0, 0, 0, 3, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0}, '{1, 0, 1, 0, 1, 0, 1}, '{0, 1, 0, 1, 1, 0, 2},
            '{0, 0, 0, 0, 1, 0, 2}
        };
        foreach (tbl[i]) begin
            cyc(tbl[i].sam, tbl[i].sym);
            chk_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].se, tbl[i].ye, tbl[i].idx, tbl[i].err);
        end

        reset = 1'b1;
        cyc(0, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_sym(-1, 0, 0, -1, 1);
            chk($sformatf("nominal sym%0d errors", i), sam_n + sym_n, 0);
        end
        chk("not locked before 5th sym", bus.locked, 0);
        run_sym(-1, 0, 0, -1, 1);
        chk("lock on 5th sym", lock_k, 0);
        run_sym(-1, 0, 0, -1, 1);
        chk("stays locked", unlock_k, -1);
        chk("nominal err_cnt", bus.err_cnt, 0);

        run_sym(-1, 0, 2, -1, 1);
        chk("early sam_err cycle", sam_k, 2);
        chk("early sam_err count", sam_n, 1);
        chk("early no sym_err", sym_n, 0);
        chk("early err_cnt", bus.err_cnt, 1);
        run_sym(-1, 0, 0, -1, 1);
        chk("locked after one dirty", unlock_k, -1);
        run_sym(-1, 0, 2, -1, 0);
        chk("second early err_cnt", bus.err_cnt, 2);
        run_sym(-1, 0, 0, -1, 0);
        chk("bad_cnt was cleared", unlock_k, -1);

        run_sym(1, 0, 0, -1, 0);
        chk("missing sam_err cycle", sam_k, 5);
        chk("missing sam_err once", sam_n, 1);
        chk("missing no sym_err yet", sym_n, 0);
        run_sym(1, 0, 0, -1, 0);
        chk("framing sym_err cycle", sym_k, 0);
        chk("second missing sam_err", sam_n, 1);
        chk("locked after first dirty eval", bus.locked, 1);
        run_sym(-1, 0, 0, -1, 0);
        chk("unlock on second dirty eval", unlock_k, 0);
        chk("framing sym_err again", sym_k, 0);
        chk("err_cnt after missing", bus.err_cnt, 6);

        run_sym(-1, 0, 0, -1, 0);
        run_sym(-1, 1, 0, -1, 1);
        chk("missing sym sym_err cycle", sym_k, 0);
        chk("missing sym pulses", sym_n + sam_n, 1);
        chk("missing sym err_cnt", bus.err_cnt, 7);

        run_sym(-1, 0, 0, -1, 0);
        run_sym(-1, 0, 0, 2, 1);
        chk("stray sym_err cycle", sym_k, 2);
        chk("stray err_cnt", bus.err_cnt, 8);
        for (int i = 0; i < 3; i++) run_sym(-1, 0, 0, -1, 0);
        chk("not locked after 3 clean", bus.locked, 0);
        run_sym(-1, 0, 0, -1, 0);
        chk("relock after 4 clean", lock_k, 0);

        cyc(1, 1);
        cyc(0, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("locked before reset", bus.locked, 1);
        reset = 1'b1;
        cyc(1, 0);
        chk_all("mid reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) cyc(0, 1);
        chk("flood sym_err", bus.sym_err, 1);
        chk("err_cnt saturates", bus.err_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
